// File: rtl/iccm_boot_pkg.sv
// Shared types and helpers for the UART ICCM boot loader.
// Imported by the receiver and by the top-level load controller.
package iccm_boot_pkg;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_e;

    typedef enum logic [1:0] {
        LEN,
        LOAD,
        DONE,
        ERROR
    } ld_state_e;

    localparam int BYTES_PER_WORD = 4;

    // Little-endian assembly: the newest byte becomes the top byte.
    function automatic logic [31:0] le_push(
        input logic [23:0] w,
        input logic [7:0]  b
    );
        return {b, w};
    endfunction

endpackage

// File: rtl/iccm_boot_loader_if.sv
// ICCM write port bundle: request, write enable, word address, data.
// The loader drives the master side and the ICCM takes the slave side.
interface iccm_boot_loader_if #(
    parameter int AW = 12
) ();

    logic          req;
    logic          we;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;

    modport master (
        output req,
        output we,
        output addr,
        output wdata
    );

    modport slave (
        input req,
        input we,
        input addr,
        input wdata
    );

endinterface

// File: rtl/iccm_boot_loader_uart_rx_lite.sv
// Minimal 8N1 UART receiver with a two-flop input synchroniser.
// byte_valid_o and frame_err_o are single-cycle registered pulses.
module uart_rx_lite
    import iccm_boot_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       rx_i,
    output logic [7:0] byte_o,
    output logic       byte_valid_o,
    output logic       frame_err_o
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

    logic [1:0]    sync_q;
    rx_state_e     state_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]    bit_q;
    logic [7:0]    shreg_q;
    logic          valid_q;
    logic          ferr_q;
    logic          rx_s;

    assign rx_s         = sync_q[1];
    assign byte_o       = shreg_q;
    assign byte_valid_o = valid_q;
    assign frame_err_o  = ferr_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync_q  <= 2'b11;
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], rx_i};
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            unique case (state_q)
                RX_IDLE: begin
                    if (!rx_s) begin
                        cnt_q   <= HALF;
                        state_q <= RX_START;
                    end
                end
                RX_START: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CW'(1);
                    end else if (rx_s) begin
                        // Start bit gone by mid-bit: treat as a glitch.
                        state_q <= RX_IDLE;
                    end else begin
                        cnt_q   <= FULL;
                        bit_q   <= '0;
                        state_q <= RX_DATA;
                    end
                end
                RX_DATA: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CW'(1);
                    end else begin
                        shreg_q <= {rx_s, shreg_q[7:1]};
                        cnt_q   <= FULL;
                        if (bit_q == 3'd7) begin
                            state_q <= RX_STOP;
                        end else begin
                            bit_q <= bit_q + 3'd1;
                        end
                    end
                end
                RX_STOP: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CW'(1);
                    end else begin
                        valid_q <= rx_s;
                        ferr_q  <= !rx_s;
                        state_q <= RX_IDLE;
                    end
                end
                default: state_q <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/iccm_boot_loader.sv
// UART boot loader: length word, then N data words written into the ICCM.
// Holds the core in reset until the image is complete.
module iccm_boot_loader
    import iccm_boot_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int ICCM_AW      = 12
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                rx_i,
    iccm_boot_loader_if.master  iccm_o,
    output logic                boot_done_o,
    output logic                core_rst_no,
    output logic                err_o
);

    localparam int RW = ICCM_AW + 1;
    localparam logic [31:0] MAX_WORDS = 32'(1) << ICCM_AW;
    localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_WORD - 1);

    logic [7:0]         rx_byte;
    logic               rx_valid;
    logic               rx_ferr;

    ld_state_e          ld_q;
    logic [1:0]         bcnt_q;
    logic [23:0]        word_q;
    logic [RW-1:0]      rem_q;
    logic [ICCM_AW-1:0] addr_q;
    logic               req_q;
    logic [ICCM_AW-1:0] waddr_q;
    logic [31:0]        wdata_q;
    logic               done_q;
    logic               err_q;

    logic [31:0]        word_d;
    logic               last_byte;

    uart_rx_lite #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .rx_i         (rx_i),
        .byte_o       (rx_byte),
        .byte_valid_o (rx_valid),
        .frame_err_o  (rx_ferr)
    );

    assign word_d    = le_push(word_q, rx_byte);
    assign last_byte = (bcnt_q == LAST_BYTE);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ld_q    <= LEN;
            bcnt_q  <= '0;
            word_q  <= '0;
            rem_q   <= '0;
            addr_q  <= '0;
            req_q   <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            req_q <= 1'b0;
            unique case (ld_q)
                LEN: begin
                    if (rx_ferr) begin
                        ld_q  <= ERROR;
                        err_q <= 1'b1;
                    end else if (rx_valid) begin
                        word_q <= word_d[31:8];
                        bcnt_q <= bcnt_q + 2'd1;
                        if (last_byte) begin
                            if (word_d == '0) begin
                                ld_q <= DONE;
                            end else if (word_d > MAX_WORDS) begin
                                ld_q  <= ERROR;
                                err_q <= 1'b1;
                            end else begin
                                rem_q  <= word_d[RW-1:0];
                                addr_q <= '0;
                                ld_q   <= LOAD;
                            end
                        end
                    end
                end
                LOAD: begin
                    if (rx_ferr) begin
                        ld_q  <= ERROR;
                        err_q <= 1'b1;
                    end else if (rx_valid) begin
                        word_q <= word_d[31:8];
                        bcnt_q <= bcnt_q + 2'd1;
                        if (last_byte) begin
                            req_q   <= 1'b1;
                            waddr_q <= addr_q;
                            wdata_q <= word_d;
                            addr_q  <= addr_q + ICCM_AW'(1);
                            rem_q   <= rem_q - RW'(1);
                            if (rem_q == RW'(1)) begin
                                ld_q <= DONE;
                            end
                        end
                    end
                end
                // Done flag lags the state by one cycle so it follows the write pulse.
                DONE:    done_q <= 1'b1;
                ERROR:   err_q  <= 1'b1;
                default: ld_q   <= ERROR;
            endcase
        end
    end

    assign iccm_o.req   = req_q;
    assign iccm_o.we    = req_q;
    assign iccm_o.addr  = waddr_q;
    assign iccm_o.wdata = wdata_q;
    assign boot_done_o  = done_q;
    assign core_rst_no  = done_q;
    assign err_o        = err_q;

endmodule

// File: tb/tb_iccm_boot_loader.sv
// Directed bench for iccm_boot_loader at 4 clocks per UART bit.
// A monitor logs every ICCM write; steps compare against fixed images.
module tb_iccm_boot_loader;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rx = 1'b1;
    logic done;
    logic crst;
    logic err;

    int checks = 0;
    int failures = 0;

    iccm_boot_loader_if #(.AW(12)) ifc ();

    iccm_boot_loader #(
        .CLKS_PER_BIT(4),
        .ICCM_AW(12)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .rx_i        (rx),
        .iccm_o      (ifc),
        .boot_done_o (done),
        .core_rst_no (crst),
        .err_o       (err)
    );

    always #5 clk = ~clk;

    logic [11:0] wr_addr[$];
    logic [31:0] wr_data[$];
    int cyc = 0;
    int last_req_cyc = -100;
    int done_rise_cyc = -1;
    int run_err = 0;
    int we_err = 0;
    logic req_prev = 1'b0;
    logic done_prev = 1'b0;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (ifc.req === 1'b1) begin
            wr_addr.push_back(ifc.addr);
            wr_data.push_back(ifc.wdata);
            if (req_prev) run_err = run_err + 1;
            if (ifc.we !== 1'b1) we_err = we_err + 1;
            last_req_cyc = cyc;
        end
        if (done === 1'b1 && !done_prev) done_rise_cyc = cyc;
        req_prev = (ifc.req === 1'b1);
        done_prev = (done === 1'b1);
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        wait_clk(4);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            wait_clk(4);
        end
        rx = stop;
        wait_clk(4);
        rx = 1'b1;
        wait_clk(4);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        wait_clk(2);
        rst_n = 1'b1;
        wr_addr.delete();
        wr_data.delete();
        done_rise_cyc = -1;
        run_err = 0;
        we_err = 0;
    endtask

    initial begin
        #400000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        wait_clk(3);
        chk("rst_req", ifc.req, 0);
        chk("rst_done", done, 0);
        chk("rst_crst", crst, 0);
        chk("rst_err", err, 0);
        do_reset();

        // Two-word image.
        send_word(32'h0000_0002);
        send_word(32'hDEAD_BEEF);
        chk("t1_done_pre", done, 0);
        send_word(32'h0000_0013);
        chk("t1_nwr", wr_addr.size(), 2);
        chk("t1_a0", wr_addr[0], 12'h000);
        chk("t1_d0", wr_data[0], 32'hDEAD_BEEF);
        chk("t1_a1", wr_addr[1], 12'h001);
        chk("t1_d1", wr_data[1], 32'h0000_0013);
        chk("t1_done", done, 1);
        chk("t1_crst", crst, 1);
        chk("t1_err", err, 0);
        chk("t1_lat", done_rise_cyc - last_req_cyc, 1);
        chk("t1_pulse", run_err, 0);
        chk("t1_we", we_err, 0);
        send_byte(8'hAA, 1'b1);
        chk("t1_post_nwr", wr_addr.size(), 2);
        chk("t1_post_done", done, 1);

        // Zero-length image.
        do_reset();
        chk("t2_done_pre", done, 0);
        send_word(32'h0000_0000);
        chk("t2_nwr", wr_addr.size(), 0);
        chk("t2_done", done, 1);
        chk("t2_crst", crst, 1);
        send_byte(8'hAA, 1'b1);
        chk("t2_post_nwr", wr_addr.size(), 0);
        chk("t2_post_done", done, 1);
        chk("t2_post_err", err, 0);

        // Length one past capacity.
        do_reset();
        send_word(32'h0000_1001);
        chk("t3_err", err, 1);
        chk("t3_crst", crst, 0);
        chk("t3_done", done, 0);
        send_word(32'h0000_0001);
        send_word(32'h1234_5678);
        chk("t3_nwr", wr_addr.size(), 0);
        chk("t3_err2", err, 1);

        // Start-bit glitch then a normal one-word image.
        do_reset();
        rx = 1'b0;
        wait_clk(1);
        rx = 1'b1;
        wait_clk(50);
        chk("t4_err", err, 0);
        chk("t4_done", done, 0);
        send_word(32'h0000_0001);
        send_word(32'h1234_5678);
        chk("t4_nwr", wr_addr.size(), 1);
        chk("t4_a0", wr_addr[0], 12'h000);
        chk("t4_d0", wr_data[0], 32'h1234_5678);
        chk("t4_done", done, 1);

        // Framing error mid-load.
        do_reset();
        send_word(32'h0000_0002);
        send_word(32'h1122_3344);
        chk("t5_nwr1", wr_addr.size(), 1);
        chk("t5_d0", wr_data[0], 32'h1122_3344);
        send_byte(8'h55, 1'b0);
        chk("t5_err", err, 1);
        send_word(32'h5566_7788);
        chk("t5_nwr2", wr_addr.size(), 1);
        chk("t5_done", done, 0);
        chk("t5_crst", crst, 0);

        // Reset in the middle of a load, then a fresh image.
        do_reset();
        send_word(32'h0000_0003);
        send_word(32'hAABB_CCDD);
        chk("t6_nwr_pre", wr_addr.size(), 1);
        do_reset();
        chk("t6_rst_done", done, 0);
        send_word(32'h0000_0001);
        send_word(32'hCAFE_F00D);
        chk("t6_nwr", wr_addr.size(), 1);
        chk("t6_a0", wr_addr[0], 12'h000);
        chk("t6_d0", wr_data[0], 32'hCAFE_F00D);
        chk("t6_done", done, 1);
        chk("t6_err", err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
